// File: rtl/grid_frame_renderer_pkg.sv
// rtl/grid_frame_renderer_pkg.sv - shared encodings for the board frame renderer
package grid_frame_renderer_pkg;

  localparam int BOARD_DIM = 3;
  localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_P1    = 2'd1;
  localparam logic [1:0] CELL_P2    = 2'd2;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_DRAW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Stored cell value to fill colour; the unused code 3 shows as white so it is visible on screen.
  function automatic logic [2:0] cell_colour(input logic [1:0] value);
    case (value)
      CELL_EMPTY: cell_colour = COL_BLACK;
      CELL_P1:    cell_colour = COL_BLUE;
      CELL_P2:    cell_colour = COL_RED;
      default:    cell_colour = COL_WHITE;
    endcase
  endfunction

endpackage

// File: rtl/grid_frame_renderer_if.sv
// rtl/grid_frame_renderer_if.sv - pixel plot request bus towards the VGA plotter
interface grid_frame_renderer_if;
  logic       plot_valid;
  logic       plot_ready;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;

  modport master (output plot_valid, output plot_x, output plot_y, output plot_colour,
                  input plot_ready);
  modport slave  (input plot_valid, input plot_x, input plot_y, input plot_colour,
                  output plot_ready);
endinterface

// File: rtl/grid_cell_origin.sv
// rtl/grid_cell_origin.sv - maps a board cell index to its top-left screen pixel
module grid_cell_origin
  import grid_frame_renderer_pkg::*;
#(
  parameter int CELL_SIZE = 8,
  parameter int ORIGIN_X  = 0,
  parameter int ORIGIN_Y  = 0
) (
  input  logic [3:0] cell_idx_i,
  output logic [7:0] base_x_o,
  output logic [6:0] base_y_o
);

  int col;
  int row;

  // Row-major split of the index; out-of-range indices collapse onto the board origin.
  always_comb begin
    col = 0;
    row = 0;
    if (cell_idx_i < 4'(NUM_CELLS)) begin
      col = int'(cell_idx_i) % BOARD_DIM;
      row = int'(cell_idx_i) / BOARD_DIM;
    end
    base_x_o = 8'(ORIGIN_X + col * CELL_SIZE);
    base_y_o = 7'(ORIGIN_Y + row * CELL_SIZE);
  end

endmodule

// File: rtl/grid_frame_renderer.sv
// rtl/grid_frame_renderer.sv - walks the nine board cells and streams their pixels to the plotter
module grid_frame_renderer
  import grid_frame_renderer_pkg::*;
#(
  parameter int CELL_SIZE = 8,
  parameter int ORIGIN_X  = 0,
  parameter int ORIGIN_Y  = 0
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [3:0]                   cursor,
  output logic [3:0]                   cell_addr,
  input  logic [1:0]                   cell_data,
  grid_frame_renderer_if.master        plot,
  output logic                         busy,
  output logic                         done
);

  localparam int             PW        = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
  localparam logic [PW-1:0]  PX_LAST   = PW'(CELL_SIZE - 1);
  localparam logic [3:0]     LAST_CELL = 4'(NUM_CELLS - 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    cell_q, cell_d;
  logic [3:0]    cursor_q, cursor_d;
  logic [3:0]    cell_addr_q, cell_addr_d;
  logic [2:0]    colour_q, colour_d;
  logic [PW-1:0] px_q, px_d;
  logic [PW-1:0] py_q, py_d;

  logic [7:0]    base_x;
  logic [6:0]    base_y;
  logic          draw;
  logic          on_border;
  logic [2:0]    pix_colour;

  grid_cell_origin #(
    .CELL_SIZE (CELL_SIZE),
    .ORIGIN_X  (ORIGIN_X),
    .ORIGIN_Y  (ORIGIN_Y)
  ) u_origin (
    .cell_idx_i (cell_q),
    .base_x_o   (base_x),
    .base_y_o   (base_y)
  );

  // Frame sequencer: fetch, latch and raster-draw each cell, one pixel per accepted request.
  always_comb begin
    state_d  = state_q;
    cell_d   = cell_q;
    cursor_d = cursor_q;
    colour_d = colour_q;
    px_d     = px_q;
    py_d     = py_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FETCH;
          cursor_d = cursor;
          cell_d   = 4'd0;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        colour_d = cell_colour(cell_data);
        px_d     = '0;
        py_d     = '0;
        state_d  = ST_DRAW;
      end
      ST_DRAW: begin
        if (plot.plot_ready) begin
          if (px_q == PX_LAST) begin
            px_d = '0;
            if (py_q == PX_LAST) begin
              py_d = '0;
              if (cell_q == LAST_CELL) begin
                state_d = ST_DONE;
              end else begin
                cell_d  = cell_q + 4'd1;
                state_d = ST_FETCH;
              end
            end else begin
              py_d = py_q + PW'(1);
            end
          end else begin
            px_d = px_q + PW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // The read address only moves when a fetch begins, so storage sees a steady address otherwise.
    cell_addr_d = (state_d == ST_FETCH) ? cell_d : cell_addr_q;
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cell_q      <= '0;
      cursor_q    <= '0;
      cell_addr_q <= '0;
      colour_q    <= '0;
      px_q        <= '0;
      py_q        <= '0;
    end else begin
      state_q     <= state_d;
      cell_q      <= cell_d;
      cursor_q    <= cursor_d;
      cell_addr_q <= cell_addr_d;
      colour_q    <= colour_d;
      px_q        <= px_d;
      py_q        <= py_d;
    end
  end

  // Pixel outputs are pure decodes of registered state, so they hold while the plotter stalls.
  always_comb begin
    draw       = (state_q == ST_DRAW);
    on_border  = (px_q == '0) || (py_q == '0) || (px_q == PX_LAST) || (py_q == PX_LAST);
    pix_colour = ((cell_q == cursor_q) && on_border) ? COL_WHITE : colour_q;
  end

  assign plot.plot_valid  = draw;
  assign plot.plot_x      = draw ? (base_x + 8'(px_q)) : 8'd0;
  assign plot.plot_y      = draw ? (base_y + 7'(py_q)) : 7'd0;
  assign plot.plot_colour = draw ? pix_colour : 3'd0;
  assign cell_addr        = cell_addr_q;
  assign busy             = (state_q == ST_FETCH) || (state_q == ST_LATCH) || (state_q == ST_DRAW);
  assign done             = (state_q == ST_DONE);

endmodule
